jtpopeye_dma_slave: RTL
=======================

# jtpopeye_dma_slave

CPU-side responder for the object DMA of the Popeye video subsystem. It takes the video block's bus request (busrq_n), arbitrates the Z80 off the bus through BUSREQ/BUSACK, and answers with busak_n. While granted, it steers main work RAM to the DMA address (AD_DMA) and returns read data on DD_DMA. It sits in the game top between the Z80, main RAM and the video block.

## Interface
Parameters:
- DMA_BASE, 12'hC00: RAM offset added to AD_DMA.
- GRANT_DLY, 2: clk cycles from cpu_busak_n low to busak_n low.
- TIMEOUT_CYC, 1023: clk cycles in REQ before a forced grant (only with JTPOPEYE_DMA_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; the single clock.
- rst  in  1  reset, asynchronous, active-high.
- busrq_n  in  1  DMA request from video, active low.
- busak_n  out  1  DMA grant to video, active low.
- dma_cs  in  1  video wants data at AD_DMA.
- AD_DMA  in  10  DMA read address.
- DD_DMA  out  8  DMA read data.
- cpu_busrq_n  out  1  to Z80 BUSRQ_n.
- cpu_busak_n  in  1  from Z80 BUSAK_n.
- cpu_addr  in  12  CPU RAM address.
- cpu_we  in  1  CPU RAM write strobe.
- cpu_dout  in  8  CPU write data.
- ram_addr  out  12  RAM address.
- ram_we  out  1  RAM write enable.
- ram_din  out  8  RAM write data.
- ram_dout  in  8  RAM read data, combinational from ram_addr.
- dma_active  out  1  high in GRANT.
- dma_err  out  1  sticky timeout flag.

## Operation
- FSM states: IDLE, REQ, HOLD, GRANT.
- IDLE: cpu_busrq_n=1, busak_n=1. If busrq_n=0, go to REQ.
- REQ: cpu_busrq_n=0. If cpu_busak_n=0, go to HOLD and clear the delay counter. If busrq_n=1, abort to IDLE; busak_n is never asserted.
- HOLD: count GRANT_DLY cycles, then go to GRANT. If busrq_n=1, go to IDLE. If cpu_busak_n returns high, go back to REQ.
- GRANT: busak_n=0, dma_active=1. If busrq_n=1, go to IDLE next clk; busak_n and cpu_busrq_n both go high on that edge.
- RAM mux:
  - In GRANT: ram_addr = DMA_BASE + {2'b0,AD_DMA}, 12-bit modulo (wraps, carry dropped); ram_we=0.
  - In any other state: ram_addr=cpu_addr, ram_we=cpu_we.
  - ram_din=cpu_dout always.
- Read data: DD_DMA is registered from ram_dout on every clk where state is GRANT and dma_cs=1. Otherwise DD_DMA holds its value.
- CPU writes during GRANT are dropped. The Z80 is halted, so none are expected.
- Reset values: busak_n=1, cpu_busrq_n=1, DD_DMA=0, dma_active=0, dma_err=0, state IDLE. Reset mid-GRANT releases the bus immediately and asynchronously.

## Timing
- busrq_n low to cpu_busrq_n low: 1 clk.
- cpu_busak_n low to busak_n low: GRANT_DLY+1 clk.
- AD_DMA/dma_cs to DD_DMA valid: 1 clk. The video side samples on pxl2_cen, whose period is at least 2 clk.
- busrq_n high to busak_n high: 1 clk.
- busrq_n rising while cpu_busak_n falls on the same edge: release wins, FSM goes to IDLE.

## Configuration
- JTPOPEYE_DMA_TIMEOUT_EN defined:
  - A 10-bit counter runs in REQ.
  - When it reaches TIMEOUT_CYC, dma_err is set (sticky until rst) and the FSM forces GRANT without cpu_busak_n.
  - The counter clears on leaving REQ.
- Undefined: no counter, dma_err is tied 0, and REQ waits indefinitely.

## Structure
- Shared package jtpopeye_pkg holds the state encoding typedef (IDLE/REQ/HOLD/GRANT) and the DMA_BASE default constant.
- One sub-module, jtpopeye_dma_addr: combinational adder and mux producing ram_addr/ram_we.
- FSM, counters and the DD_DMA register stay in the top.

## Test plan
- Basic grant: busrq_n=0, Z80 model drops cpu_busak_n 5 clk later -> busak_n=0 exactly GRANT_DLY+1 clk after; dma_active=1.
- Data read: RAM[0xC00+0x3F]=0xA5, GRANT, AD_DMA=0x03F with dma_cs=1 -> DD_DMA=0xA5 one clk later, ram_addr=0xC3F.
- Wrap: DMA_BASE=0xF00, AD_DMA=0x200 -> ram_addr=0x100.
- Abort: busrq_n low for 1 clk then high before cpu_busak_n -> busak_n stays 1, cpu_busrq_n back to 1 in 1 clk.
- CPU isolation: cpu_we=1 at cpu_addr=0x010 during GRANT -> ram_we=0, RAM unchanged. After release, the same write succeeds.
- Timeout (JTPOPEYE_DMA_TIMEOUT_EN, TIMEOUT_CYC=16): cpu_busak_n held high -> dma_err=1 and busak_n=0 after 16 clk in REQ. Assert rst mid-GRANT -> busak_n=1, dma_err=0 immediately.

Source files
------------

// File: rtl/jtpopeye_pkg.sv
// Shared definitions for the Popeye object-DMA CPU-side responder.
package jtpopeye_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_REQ   = 2'd1,
      ST_HOLD  = 2'd2,
      ST_GRANT = 2'd3
   } dma_state_t;

   localparam logic [11:0] DMA_BASE_DEF = 12'hC00;

endpackage

// File: rtl/jtpopeye_dma_addr.sv
// Main RAM address/write-enable steering between the Z80 and the video DMA.
module jtpopeye_dma_addr
   import jtpopeye_pkg::*;
#(
   parameter logic [11:0] DMA_BASE = DMA_BASE_DEF
) (
   input  logic        grant,
   input  logic [9:0]  ad_dma,
   input  logic [11:0] cpu_addr,
   input  logic        cpu_we,
   output logic [11:0] ram_addr,
   output logic        ram_we
);

   logic [11:0] dma_addr;

   // 12-bit sum: a base near the top of RAM wraps round to the bottom.
   assign dma_addr = DMA_BASE + {2'b00, ad_dma};

   always_comb begin
      ram_addr = cpu_addr;
      ram_we   = cpu_we;
      if (grant) begin
         ram_addr = dma_addr;
         ram_we   = 1'b0;
      end
   end

endmodule

// File: rtl/jtpopeye_dma_slave.sv
// CPU-side responder for the Popeye object DMA: takes the Z80 off the bus and serves DMA reads.
// Optional macro JTPOPEYE_DMA_TIMEOUT_EN forces a grant (and sets dma_err) if the Z80 never acknowledges.
module jtpopeye_dma_slave
   import jtpopeye_pkg::*;
#(
   parameter logic [11:0] DMA_BASE    = DMA_BASE_DEF,
   parameter int          GRANT_DLY   = 2,
   parameter int          TIMEOUT_CYC = 1023
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        busrq_n,
   output logic        busak_n,
   input  logic        dma_cs,
   input  logic [9:0]  AD_DMA,
   output logic [7:0]  DD_DMA,
   output logic        cpu_busrq_n,
   input  logic        cpu_busak_n,
   input  logic [11:0] cpu_addr,
   input  logic        cpu_we,
   input  logic [7:0]  cpu_dout,
   output logic [11:0] ram_addr,
   output logic        ram_we,
   output logic [7:0]  ram_din,
   input  logic [7:0]  ram_dout,
   output logic        dma_active,
   output logic        dma_err
);

   localparam logic [7:0] DLY_LAST = (GRANT_DLY > 1) ? 8'(GRANT_DLY - 1) : 8'd0;

   dma_state_t  state_q, state_d;
   logic [7:0]  dly_q, dly_d;
   logic        busak_n_q, busak_n_d;
   logic        cpu_busrq_n_q, cpu_busrq_n_d;
   logic        dma_active_q, dma_active_d;
   logic [7:0]  dd_q, dd_d;

`ifdef JTPOPEYE_DMA_TIMEOUT_EN
   localparam logic [9:0] TMO_LAST = 10'(TIMEOUT_CYC - 1);
   logic [9:0]  tmo_q, tmo_d;
   logic        err_q, err_d;
`else
   logic        unused_tmo_cfg;
   assign unused_tmo_cfg = ^TIMEOUT_CYC;
`endif

   always_comb begin
      state_d = state_q;
      dly_d   = dly_q;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      err_d   = err_q;
`endif
      // Release (busrq_n high) always takes priority over any Z80 handshake.
      case (state_q)
         ST_IDLE:  if (!busrq_n) state_d = ST_REQ;
         ST_REQ: begin
            if (busrq_n)
               state_d = ST_IDLE;
            else if (!cpu_busak_n)
               state_d = ST_HOLD;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
            else if (tmo_q == TMO_LAST) begin
               state_d = ST_GRANT;
               err_d   = 1'b1;
            end
`endif
         end
         ST_HOLD: begin
            if (busrq_n)
               state_d = ST_IDLE;
            else if (cpu_busak_n)
               state_d = ST_REQ;
            else if (dly_q >= DLY_LAST)
               state_d = ST_GRANT;
            else
               dly_d = dly_q + 8'd1;
         end
         ST_GRANT: if (busrq_n) state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase

      if (state_d != ST_HOLD)
         dly_d = '0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
      tmo_d = (state_q == ST_REQ && state_d == ST_REQ) ? tmo_q + 10'd1 : 10'd0;
`endif

      // Bus handshake outputs are registered from the next state.
      busak_n_d     = (state_d != ST_GRANT);
      cpu_busrq_n_d = (state_d == ST_IDLE);
      dma_active_d  = (state_d == ST_GRANT);
      dd_d          = (state_q == ST_GRANT && dma_cs) ? ram_dout : dd_q;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         dly_q         <= '0;
         busak_n_q     <= 1'b1;
         cpu_busrq_n_q <= 1'b1;
         dma_active_q  <= 1'b0;
         dd_q          <= '0;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
         tmo_q         <= '0;
         err_q         <= 1'b0;
`endif
      end else begin
         state_q       <= state_d;
         dly_q         <= dly_d;
         busak_n_q     <= busak_n_d;
         cpu_busrq_n_q <= cpu_busrq_n_d;
         dma_active_q  <= dma_active_d;
         dd_q          <= dd_d;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
         tmo_q         <= tmo_d;
         err_q         <= err_d;
`endif
      end
   end

   jtpopeye_dma_addr #(
      .DMA_BASE (DMA_BASE)
   ) u_addr (
      .grant    (state_q == ST_GRANT),
      .ad_dma   (AD_DMA),
      .cpu_addr (cpu_addr),
      .cpu_we   (cpu_we),
      .ram_addr (ram_addr),
      .ram_we   (ram_we)
   );

   assign busak_n     = busak_n_q;
   assign cpu_busrq_n = cpu_busrq_n_q;
   assign dma_active  = dma_active_q;
   assign DD_DMA      = dd_q;
   assign ram_din     = cpu_dout;
`ifdef JTPOPEYE_DMA_TIMEOUT_EN
   assign dma_err     = err_q;
`else
   assign dma_err     = 1'b0;
`endif

endmodule
